// File: rtl/lif_membrane_update.sv
// Leaky-integrate-and-fire membrane stage: integrates I_syn with leak toward V_REST,
// fires on the comparator's NonORoff request, then holds V_RESET for REF_STEPS strobes.
module lif_membrane_update #(
    parameter int buffer_size = 16,
    parameter int V_REST      = 0,
    parameter int V_RESET     = 0,
    parameter int LEAK_SHIFT  = 4,
    parameter int REF_STEPS   = 3,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step_en,
    input  logic signed [buffer_size-1:0] I_syn,
    input  logic                          NonORoff,
    output logic signed [buffer_size-1:0] V_mem,
    output logic                          spike,
    output logic                          refractory,
    output logic        [CNT_W-1:0]       spike_cnt
);

    localparam int EW   = buffer_size + 2;
    localparam int RC_W = (REF_STEPS > 0) ? $clog2(REF_STEPS + 1) : 1;

    localparam logic signed [buffer_size-1:0] VREST_C  = buffer_size'(V_REST);
    localparam logic signed [buffer_size-1:0] VRESET_C = buffer_size'(V_RESET);
    localparam logic signed [EW-1:0] SAT_MAX = EW'((longint'(1) <<< (buffer_size - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(longint'(1) <<< (buffer_size - 1)));

    typedef enum logic {
        S_INTEGRATE,
        S_REFRACT
    } state_t;

    state_t                        state_q, state_d;
    logic signed [buffer_size-1:0] vm_q, vm_d;
    logic        [RC_W-1:0]        rcnt_q, rcnt_d;
    logic                          spike_q, spike_d;
    logic        [CNT_W-1:0]       scnt_q, scnt_d;

    logic signed [EW-1:0]          vm_ext, is_ext, leak_ext, sum_ext;
    logic signed [buffer_size-1:0] vm_int;

    // Two guard bits hold V_mem + I_syn - leak without wrap before clamping.
    always_comb begin
        vm_ext   = EW'(vm_q);
        is_ext   = EW'(I_syn);
        leak_ext = (vm_ext - EW'(VREST_C)) >>> LEAK_SHIFT;
        sum_ext  = vm_ext + is_ext - leak_ext;
        if (sum_ext > SAT_MAX) begin
            vm_int = SAT_MAX[buffer_size-1:0];
        end else if (sum_ext < SAT_MIN) begin
            vm_int = SAT_MIN[buffer_size-1:0];
        end else begin
            vm_int = sum_ext[buffer_size-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        vm_d    = vm_q;
        rcnt_d  = rcnt_q;
        spike_d = 1'b0;
        scnt_d  = scnt_q;
        if (step_en) begin
            unique case (state_q)
                S_INTEGRATE: begin
                    if (NonORoff) begin
                        spike_d = 1'b1;
                        vm_d    = VRESET_C;
                        if (scnt_q != '1) begin
                            scnt_d = scnt_q + 1'b1;
                        end
                        if (REF_STEPS > 0) begin
                            state_d = S_REFRACT;
                            rcnt_d  = RC_W'(REF_STEPS);
                        end
                    end else begin
                        vm_d = vm_int;
                    end
                end
                S_REFRACT: begin
                    vm_d   = VRESET_C;
                    rcnt_d = rcnt_q - 1'b1;
                    if (rcnt_q == RC_W'(1)) begin
                        state_d = S_INTEGRATE;
                    end
                end
                default: state_d = S_INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INTEGRATE;
            vm_q    <= VREST_C;
            rcnt_q  <= '0;
            spike_q <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vm_q    <= vm_d;
            rcnt_q  <= rcnt_d;
            spike_q <= spike_d;
            scnt_q  <= scnt_d;
        end
    end

    assign V_mem      = vm_q;
    assign spike      = spike_q;
    assign refractory = (state_q == S_REFRACT);
    assign spike_cnt  = scnt_q;

endmodule

// File: tb/tb_lif_membrane_update.sv
// Bench for lif_membrane_update: directed vector table, reset corner cases, and
// random strobes checked against an arithmetic LIF reference model.
module tb_lif_membrane_update;

    localparam int W      = 16;
    localparam int REF_N  = 3;
    localparam int SH     = 4;
    localparam int VMAX   = 32767;
    localparam int VMIN   = -32768;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                step_en = 1'b0;
    logic signed [W-1:0] I_syn = '0;
    logic                NonORoff = 1'b0;
    logic signed [W-1:0] V_mem;
    logic                spike;
    logic                refractory;
    logic        [15:0]  spike_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_vm, m_rem, m_cnt;
    bit m_spk;

    lif_membrane_update #(
        .buffer_size(W),
        .V_REST(0),
        .V_RESET(0),
        .LEAK_SHIFT(SH),
        .REF_STEPS(REF_N),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step_en(step_en),
        .I_syn(I_syn),
        .NonORoff(NonORoff),
        .V_mem(V_mem),
        .spike(spike),
        .refractory(refractory),
        .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit nof;
        int isyn;
        int vm;
        bit spk;
        bit refr;
        int cnt;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int vm, input bit spk, input bit refr, input int cnt);
        check({tag, ".V_mem"}, int'(V_mem), vm);
        check({tag, ".spike"}, int'(spike), int'(spk));
        check({tag, ".refractory"}, int'(refractory), int'(refr));
        check({tag, ".spike_cnt"}, int'(spike_cnt), cnt);
    endtask

    task automatic cycle(input bit en, input bit nof, input int isyn);
        @(negedge clk);
        step_en  = en;
        NonORoff = nof;
        I_syn    = W'(isyn);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step_en = 1'b0;
        #3;
        rst = 1'b0;
    endtask

    function automatic int model_sat(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    // Spec rules in plain integer arithmetic; refractory is "strobes still to spend".
    task automatic model_step(input bit en, input bit nof, input int isyn);
        m_spk = 1'b0;
        if (en) begin
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                m_vm  = 0;
            end else if (nof) begin
                m_spk = 1'b1;
                m_vm  = 0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                m_rem = REF_N;
            end else begin
                m_vm = model_sat(m_vm + isyn - ((m_vm - 0) >>> SH));
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 160,    160,    0, 0, 0};
        tbl[1]  = '{1, 0, 160,    310,    0, 0, 0};
        tbl[2]  = '{1, 0, 0,      291,    0, 0, 0};
        tbl[3]  = '{1, 1, 777,    0,      1, 1, 1};
        tbl[4]  = '{1, 0, 500,    0,      0, 1, 1};
        tbl[5]  = '{1, 1, 500,    0,      0, 1, 1};
        tbl[6]  = '{1, 0, 500,    0,      0, 0, 1};
        tbl[7]  = '{1, 0, 500,    500,    0, 0, 1};
        tbl[8]  = '{0, 1, 1000,   500,    0, 0, 1};
        tbl[9]  = '{1, 1, 0,      0,      1, 1, 2};
        tbl[10] = '{1, 0, 0,      0,      0, 1, 2};
        tbl[11] = '{1, 0, 0,      0,      0, 1, 2};
        tbl[12] = '{1, 0, 0,      0,      0, 0, 2};
        tbl[13] = '{1, 0, 32767,  32767,  0, 0, 2};
        tbl[14] = '{1, 0, 32767,  32767,  0, 0, 2};
        tbl[15] = '{1, 1, 0,      0,      1, 1, 3};
        tbl[16] = '{1, 0, 0,      0,      0, 1, 3};
        tbl[17] = '{1, 0, 0,      0,      0, 1, 3};
        tbl[18] = '{1, 0, 0,      0,      0, 0, 3};
        tbl[19] = '{1, 0, -32768, -32768, 0, 0, 3};
        tbl[20] = '{1, 0, -32768, -32768, 0, 0, 3};
        tbl[21] = '{1, 0, 0,      -30720, 0, 0, 3};
        tbl[22] = '{0, 0, 0,      -30720, 0, 0, 3};

        do_reset();
        #1;
        check_all("reset", 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].en, tbl[i].nof, tbl[i].isyn);
            check_all($sformatf("vec%0d", i), tbl[i].vm, tbl[i].spk, tbl[i].refr, tbl[i].cnt);
        end

        // hold: ten idle cycles with aggressive inputs change nothing
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1000);
            check_all($sformatf("hold%0d", i), -30720, 0, 0, 3);
        end

        // asynchronous reset mid-cycle takes effect before the next edge
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // reset while refractory counter is 2, then integrate on the first strobe
        cycle(1'b1, 1'b1, 0);
        check_all("arm_fire", 0, 1, 1, 1);
        cycle(1'b1, 1'b0, 0);
        check_all("ref_cnt2", 0, 0, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("rst_in_ref", 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 100);
        check_all("post_rst_int", 100, 0, 0, 0);

        // random strobes against the reference model
        do_reset();
        m_vm = 0; m_rem = 0; m_cnt = 0; m_spk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit en, nof;
            int isyn;
            en   = ($urandom_range(0, 3) != 0);
            nof  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       isyn = $urandom_range(0, 65535) - 32768;
                1:       isyn = (($urandom_range(0, 1) == 1) ? VMAX : VMIN);
                default: isyn = $urandom_range(0, 2000) - 1000;
            endcase
            cycle(en, nof, isyn);
            model_step(en, nof, isyn);
            check_all($sformatf("rnd%0d", i), m_vm, m_spk, (m_rem > 0), m_cnt);
        end

        step_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
